// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RISC-V in-order pipeline stage registers.
package rv_pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ILEN_DEF = 32;

    // addi x0, x0, 0 -- the canonical bubble presented to decode
    localparam logic [ILEN_DEF-1:0] NOP_INSTR = 32'h00000013;

    // Everything fetch hands to decode for one instruction
    typedef struct packed {
        logic [ILEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
        logic                pred_taken;
        logic [XLEN_DEF-1:0] pred_target;
    } if_id_payload_t;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch-to-decode bundle: upstream and downstream valid/ready handshakes,
// hazard flush and the performance counters.
//
// Handshake: a beat moves on a rising clk edge where valid && ready are both
// high; the sender holds payload stable while valid && !ready; ready never
// waits on valid, and a flush in the same cycle overrides any beat.
interface if_id_pipe_reg_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int CNT_W = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [ILEN-1:0]  in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;

    logic             out_valid;
    logic             out_ready;
    logic [ILEN-1:0]  out_instr;
    logic [XLEN-1:0]  out_pc;
    logic             out_pred_taken;
    logic [XLEN-1:0]  out_pred_target;

    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Environment side: fetch, decode and hazard unit
    modport master (
        output in_valid, in_instr, in_pc, in_pred_taken, in_pred_target,
        output out_ready, flush,
        input  in_ready, out_valid, out_instr, out_pc, out_pred_taken,
        input  out_pred_target, stall_cnt, flush_cnt
    );

    // Pipeline register side
    modport slave (
        input  in_valid, in_instr, in_pc, in_pred_taken, in_pred_target,
        input  out_ready, flush,
        output in_ready, out_valid, out_instr, out_pc, out_pred_taken,
        output out_pred_target, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer. in_ready depends only on a flop, so the
// upstream ready path is cut; one extra entry absorbs the beat that arrives
// while downstream stalls. Flush drops both entries but keeps the data flops.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         skid_valid
);

    logic         main_valid_q;
    logic         skid_valid_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         xfer;
    logic         consume;

    assign in_ready   = !skid_valid_q;
    assign xfer       = in_valid && !skid_valid_q;
    assign consume    = main_valid_q && out_ready;
    assign out_valid  = main_valid_q;
    assign out_data   = main_q;
    assign skid_valid = skid_valid_q;

    // Main/skid occupancy and data: flush first, then consume, then fill
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                // in_ready was low, so no new beat can land this cycle
                main_q       <= skid_q;
                skid_valid_q <= 1'b0;
            end else if (xfer) begin
                main_q <= in_data;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (!main_valid_q) begin
            if (xfer) begin
                main_q       <= in_data;
                main_valid_q <= 1'b1;
            end
        end else if (xfer) begin
            skid_q       <= in_data;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: carries instruction, PC and prediction sideband
// from fetch to decode with a valid/ready handshake, optional skid buffer,
// flush-to-bubble and saturating stall/flush counters.
module if_id_pipe_reg #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR,
    parameter bit              SKID_EN   = 1'b1,
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    if_id_pipe_reg_if.slave   bus
);

    localparam int PW = ILEN + XLEN + 1 + XLEN;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [PW-1:0]    in_data;
    logic [PW-1:0]    main_data;
    logic             main_valid;
    logic             skid_valid;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Payload layout, MSB first: instr, pc, pred_taken, pred_target
    assign in_data = {bus.in_instr, bus.in_pc, bus.in_pred_taken, bus.in_pred_target};

    if (SKID_EN) begin : g_skid
        pipe_skid_buf #(.W(PW)) u_skid (
            .clk        (clk),
            .reset      (reset),
            .flush      (bus.flush),
            .in_valid   (bus.in_valid),
            .in_ready   (bus.in_ready),
            .in_data    (in_data),
            .out_valid  (main_valid),
            .out_ready  (bus.out_ready),
            .out_data   (main_data),
            .skid_valid (skid_valid)
        );
    end else begin : g_single
        logic          valid_q;
        logic [PW-1:0] data_q;

        assign bus.in_ready = !valid_q || bus.out_ready;
        assign main_valid   = valid_q;
        assign main_data    = data_q;
        assign skid_valid   = 1'b0;

        // Single entry: reload on transfer, empty on consume-without-refill
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (bus.in_valid && bus.in_ready) begin
                valid_q <= 1'b1;
                data_q  <= in_data;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Bubbles show NOP and not-taken; PC and target keep their last value
    assign bus.out_valid       = main_valid;
    assign bus.out_instr       = main_valid ? main_data[PW-1 -: ILEN] : NOP_INSTR;
    assign bus.out_pc          = main_data[2*XLEN -: XLEN];
    assign bus.out_pred_taken  = main_valid && main_data[XLEN];
    assign bus.out_pred_target = main_data[XLEN-1:0];
    assign bus.stall_cnt       = stall_q;
    assign bus.flush_cnt       = flush_q;

    // Saturating counters: stalled cycles, and flushes that killed something
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (main_valid && !bus.out_ready && !bus.flush && stall_q != CNT_MAX) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (bus.flush && (main_valid || skid_valid) && flush_q != CNT_MAX) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: skid build (CNT_W=16) and single-register build
// (CNT_W=4) side by side, each with an occupancy/data scoreboard.
module tb_if_id_pipe_reg;
    import rv_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    if_id_payload_t exp_q0[$];
    if_id_payload_t exp_q1[$];
    logic [15:0]    exp_stall0, exp_flush0;
    logic [3:0]     exp_stall1, exp_flush1;

    always #5 clk = ~clk;

    if_id_pipe_reg_if #(.XLEN(32), .ILEN(32), .CNT_W(16)) a ();
    if_id_pipe_reg_if #(.XLEN(32), .ILEN(32), .CNT_W(4))  b ();

    if_id_pipe_reg #(.XLEN(32), .ILEN(32), .NOP_INSTR(32'h00000013), .SKID_EN(1'b1), .CNT_W(16)) u_skid (
        .clk(clk), .reset(reset), .bus(a));
    if_id_pipe_reg #(.XLEN(32), .ILEN(32), .NOP_INSTR(32'h00000013), .SKID_EN(1'b0), .CNT_W(4)) u_single (
        .clk(clk), .reset(reset), .bus(b));

    // ---------------- scoreboard / model, skid build ----------------
    always @(negedge clk) begin : mon_a
        if_id_payload_t e, got;
        int occ;
        occ = exp_q0.size();
        if (reset) begin
            exp_q0.delete(); exp_stall0 = '0; exp_flush0 = '0;
            n_checks++;
            if (a.in_ready !== 1'b1) $display("FAIL reset_in_ready_a: got %b want 1", a.in_ready);
            else n_pass++;
        end else begin
            n_checks++;
            if (a.out_valid !== (occ != 0)) $display("FAIL valid_a: got %b want %b", a.out_valid, occ != 0);
            else n_pass++;
            n_checks++;
            if (a.in_ready !== (occ < 2)) $display("FAIL in_ready_a: got %b want %b (occ %0d)", a.in_ready, occ < 2, occ);
            else n_pass++;
            n_checks++;
            if (a.stall_cnt !== exp_stall0 || a.flush_cnt !== exp_flush0)
                $display("FAIL counters_a: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         a.stall_cnt, a.flush_cnt, exp_stall0, exp_flush0);
            else n_pass++;
            if (occ == 0) begin
                n_checks++;
                if (a.out_instr !== NOP_INSTR || a.out_pred_taken !== 1'b0)
                    $display("FAIL bubble_a: got instr=%h tk=%b want %h 0", a.out_instr, a.out_pred_taken, NOP_INSTR);
                else n_pass++;
            end
            if (a.flush) begin
                if (occ != 0 && exp_flush0 != 16'hFFFF) exp_flush0++;
                exp_q0.delete();
            end else begin
                if (occ != 0 && !a.out_ready && exp_stall0 != 16'hFFFF) exp_stall0++;
                if (occ != 0 && a.out_ready) begin
                    e = exp_q0.pop_front();
                    got = {a.out_instr, a.out_pc, a.out_pred_taken, a.out_pred_target};
                    n_checks++;
                    if (got !== e)
                        $display("FAIL sb_data_a: got instr=%h pc=%h tk=%b tgt=%h want instr=%h pc=%h tk=%b tgt=%h",
                                 got.instr, got.pc, got.pred_taken, got.pred_target,
                                 e.instr, e.pc, e.pred_taken, e.pred_target);
                    else n_pass++;
                end
                if (a.in_valid && a.in_ready) begin
                    e = {a.in_instr, a.in_pc, a.in_pred_taken, a.in_pred_target};
                    exp_q0.push_back(e);
                end
            end
        end
    end

    // ---------------- scoreboard / model, single-register build ----------------
    always @(negedge clk) begin : mon_b
        if_id_payload_t e, got;
        int occ;
        occ = exp_q1.size();
        if (reset) begin
            exp_q1.delete(); exp_stall1 = '0; exp_flush1 = '0;
            n_checks++;
            if (b.in_ready !== 1'b1) $display("FAIL reset_in_ready_b: got %b want 1", b.in_ready);
            else n_pass++;
        end else begin
            n_checks++;
            if (b.out_valid !== (occ != 0)) $display("FAIL valid_b: got %b want %b", b.out_valid, occ != 0);
            else n_pass++;
            n_checks++;
            if (b.in_ready !== (occ == 0 || b.out_ready)) $display("FAIL in_ready_b: got %b want %b", b.in_ready, occ == 0 || b.out_ready);
            else n_pass++;
            n_checks++;
            if (b.stall_cnt !== exp_stall1 || b.flush_cnt !== exp_flush1)
                $display("FAIL counters_b: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         b.stall_cnt, b.flush_cnt, exp_stall1, exp_flush1);
            else n_pass++;
            if (b.flush) begin
                if (occ != 0 && exp_flush1 != 4'hF) exp_flush1++;
                exp_q1.delete();
            end else begin
                if (occ != 0 && !b.out_ready && exp_stall1 != 4'hF) exp_stall1++;
                if (occ != 0 && b.out_ready) begin
                    e = exp_q1.pop_front();
                    got = {b.out_instr, b.out_pc, b.out_pred_taken, b.out_pred_target};
                    n_checks++;
                    if (got !== e)
                        $display("FAIL sb_data_b: got instr=%h pc=%h tk=%b tgt=%h want instr=%h pc=%h tk=%b tgt=%h",
                                 got.instr, got.pc, got.pred_taken, got.pred_target,
                                 e.instr, e.pc, e.pred_taken, e.pred_target);
                    else n_pass++;
                end
                if (b.in_valid && b.in_ready) begin
                    e = {b.in_instr, b.in_pc, b.in_pred_taken, b.in_pred_target};
                    exp_q1.push_back(e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [31:0] pc);
        a.in_valid       = 1'b1;
        a.in_pc          = pc;
        a.in_instr       = $urandom;
        a.in_pred_taken  = 1'($urandom_range(0, 1));
        a.in_pred_target = $urandom;
    endtask

    task automatic drive_b(input logic [31:0] pc);
        b.in_valid       = 1'b1;
        b.in_pc          = pc;
        b.in_instr       = $urandom;
        b.in_pred_taken  = 1'($urandom_range(0, 1));
        b.in_pred_target = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        a.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_a(32'h40 + 32'(i * 4));
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a.out_valid !== 1'b0 || a.out_instr !== 32'h00000013)
            $display("FAIL reset_async: got valid=%b instr=%h want 0 00000013", a.out_valid, a.out_instr);
        else n_pass++;
        tick(); tick(); tick();
        reset = 1'b0;
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a.out_valid !== 1'b0 || a.out_instr !== 32'h00000013 || a.out_pc !== 32'h0 ||
            a.out_pred_taken !== 1'b0 || a.out_pred_target !== 32'h0)
            $display("FAIL reset_outputs: got valid=%b instr=%h pc=%h tk=%b tgt=%h want 0 00000013 0 0 0",
                     a.out_valid, a.out_instr, a.out_pc, a.out_pred_taken, a.out_pred_target);
        else n_pass++;
        n_checks++;
        if (a.stall_cnt !== 16'd0 || a.flush_cnt !== 16'd0 || a.in_ready !== 1'b1)
            $display("FAIL reset_counters: got stall=%0d flush=%0d rdy=%b want 0 0 1",
                     a.stall_cnt, a.flush_cnt, a.in_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_stream();
        a.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive_a(32'(i * 4));
            else a.in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (i == 0) begin
                if (a.out_valid !== 1'b0) $display("FAIL stream_first: got valid=%b want 0", a.out_valid);
                else n_pass++;
            end else begin
                if (a.out_valid !== 1'b1 || a.out_pc !== 32'((i - 1) * 4))
                    $display("FAIL stream_order: got valid=%b pc=%h want 1 %h", a.out_valid, a.out_pc, 32'((i - 1) * 4));
                else n_pass++;
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (a.out_valid !== 1'b0 || a.stall_cnt !== 16'd0)
            $display("FAIL stream_end: got valid=%b stall=%0d want 0 0", a.out_valid, a.stall_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] instrs[3];
        int k = 0;
        bit fresh = 1'b1;
        bit acc;
        for (int c = 0; c < 9; c++) begin
            a.out_ready = (c >= 5);
            if (k < 3) begin
                if (fresh) begin
                    drive_a(32'h100 + 32'(k * 4));
                    instrs[k] = a.in_instr;
                end
            end else a.in_valid = 1'b0;
            @(negedge clk);
            acc = a.in_valid && a.in_ready;
            if (c >= 1 && c <= 5) begin
                n_checks++;
                if (a.out_valid !== 1'b1 || a.out_pc !== 32'h100 || a.out_instr !== instrs[0])
                    $display("FAIL stall_hold: cyc %0d got valid=%b pc=%h instr=%h want 1 00000100 %h",
                             c, a.out_valid, a.out_pc, a.out_instr, instrs[0]);
                else n_pass++;
            end
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (a.in_ready !== 1'b0) $display("FAIL stall_in_ready: cyc %0d got %b want 0", c, a.in_ready);
                else n_pass++;
            end
            if (c == 6 || c == 7) begin
                n_checks++;
                if (a.out_valid !== 1'b1 || a.out_pc !== 32'h100 + 32'((c - 5) * 4))
                    $display("FAIL stall_release: cyc %0d got valid=%b pc=%h want 1 %h",
                             c, a.out_valid, a.out_pc, 32'h100 + 32'((c - 5) * 4));
                else n_pass++;
            end
            tick();
            if (acc) k++;
            fresh = acc;
        end
        @(negedge clk);
        n_checks++;
        if (k != 3 || a.out_valid !== 1'b0 || a.stall_cnt !== 16'd4)
            $display("FAIL stall_count: got accepted=%0d valid=%b stall=%0d want 3 0 4", k, a.out_valid, a.stall_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        a.out_ready = 1'b0;
        drive_a(32'h180); tick();
        drive_a(32'h184); tick();
        drive_a(32'h200);
        a.flush = 1'b1;
        tick();
        a.flush = 1'b0;
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a.out_valid !== 1'b0 || a.out_instr !== 32'h00000013 || a.out_pred_taken !== 1'b0 || a.out_pc !== 32'h180)
            $display("FAIL flush_bubble: got valid=%b instr=%h tk=%b pc=%h want 0 00000013 0 00000180",
                     a.out_valid, a.out_instr, a.out_pred_taken, a.out_pc);
        else n_pass++;
        n_checks++;
        if (a.flush_cnt !== 16'd1 || a.stall_cnt !== 16'd5 || a.in_ready !== 1'b1)
            $display("FAIL flush_counts: got flush=%0d stall=%0d rdy=%b want 1 5 1", a.flush_cnt, a.stall_cnt, a.in_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (a.out_valid !== 1'b0) $display("FAIL flush_no_stale: got valid=%b pc=%h want 0", a.out_valid, a.out_pc);
            else n_pass++;
        end
        tick();
        // flush of an empty stage with an offered beat: beat dropped, no count
        a.flush = 1'b1;
        drive_a(32'h300);
        @(negedge clk);
        n_checks++;
        if (a.in_ready !== 1'b1) $display("FAIL flush_empty_ready: got %b want 1", a.in_ready);
        else n_pass++;
        tick();
        a.flush = 1'b0;
        a.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a.out_valid !== 1'b0 || a.flush_cnt !== 16'd1)
            $display("FAIL flush_empty: got valid=%b flush=%0d want 0 1", a.out_valid, a.flush_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic        pv, pr, pf, ptk;
        logic [31:0] pinstr, ppc, ptgt;
        bit hold_up = 1'b0;
        int seq = 0;
        pv = 1'b0; pr = 1'b1; pf = 1'b0; ptk = 1'b0; pinstr = '0; ppc = '0; ptgt = '0;
        for (int c = 0; c < 200; c++) begin
            a.out_ready = ($urandom_range(0, 3) != 0);
            a.flush = ($urandom_range(0, 24) == 0);
            if (!hold_up) begin
                if ($urandom_range(0, 4) != 0) begin
                    drive_a(32'h1000 + 32'(seq * 4));
                    seq++;
                end else a.in_valid = 1'b0;
            end
            @(negedge clk);
            if (pv && !pr && !pf) begin
                n_checks++;
                if (a.out_instr !== pinstr || a.out_pc !== ppc || a.out_pred_taken !== ptk || a.out_pred_target !== ptgt)
                    $display("FAIL hold_rule: got pc=%h instr=%h want pc=%h instr=%h", a.out_pc, a.out_instr, ppc, pinstr);
                else n_pass++;
            end
            pv = a.out_valid; pr = a.out_ready; pf = a.flush;
            pinstr = a.out_instr; ppc = a.out_pc; ptk = a.out_pred_taken; ptgt = a.out_pred_target;
            hold_up = a.in_valid && !a.in_ready;
            tick();
        end
        a.flush = 1'b0;
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (exp_q0.size() != 0) $display("FAIL drain_a: got %0d entries left want 0", exp_q0.size());
        else n_pass++;
    endtask

    task automatic test_saturation();
        b.out_ready = 1'b0;
        drive_b(32'h400);
        tick();
        b.in_valid = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 14 || i == 15 || i == 21) begin
                n_checks++;
                if (b.stall_cnt !== ((i == 14) ? 4'd14 : 4'd15) || b.out_valid !== 1'b1)
                    $display("FAIL stall_saturate: cyc %0d got stall=%0d valid=%b want %0d 1",
                             i, b.stall_cnt, b.out_valid, (i == 14) ? 14 : 15);
                else n_pass++;
            end
            tick();
        end
        b.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_noskid();
        b.out_ready = 1'b0;
        drive_b(32'h500);
        tick();
        drive_b(32'h504);
        #1;
        n_checks++;
        if (b.in_ready !== 1'b0 || b.out_pc !== 32'h500)
            $display("FAIL noskid_ready_low: got rdy=%b pc=%h want 0 00000500", b.in_ready, b.out_pc);
        else n_pass++;
        b.out_ready = 1'b1;
        #1;
        n_checks++;
        if (b.in_ready !== 1'b1) $display("FAIL noskid_ready_comb: got %b want 1", b.in_ready);
        else n_pass++;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive_b(32'h508 + 32'(i * 4));
            else b.in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (b.out_valid !== 1'b1 || b.out_pc !== 32'h504 + 32'(i * 4))
                $display("FAIL noskid_thru: got valid=%b pc=%h want 1 %h", b.out_valid, b.out_pc, 32'h504 + 32'(i * 4));
            else n_pass++;
            tick();
        end
        for (int c = 0; c < 100; c++) begin
            b.out_ready = ($urandom_range(0, 2) != 0);
            b.flush = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) != 0) drive_b(32'h2000 + 32'(c * 4));
            else b.in_valid = 1'b0;
            tick();
        end
        b.flush = 1'b0;
        b.in_valid = 1'b0;
        b.out_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (exp_q1.size() != 0) $display("FAIL drain_b: got %0d entries left want 0", exp_q1.size());
        else n_pass++;
    endtask

    // ---------------- sequence ----------------
    initial begin
        a.in_valid = 1'b0; a.in_instr = '0; a.in_pc = '0; a.in_pred_taken = 1'b0; a.in_pred_target = '0;
        a.out_ready = 1'b1; a.flush = 1'b0;
        b.in_valid = 1'b0; b.in_instr = '0; b.in_pc = '0; b.in_pred_taken = 1'b0; b.in_pred_target = '0;
        b.out_ready = 1'b1; b.flush = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_back_to_back();
        test_saturation();
        test_noskid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
